router_pkt_tx: RTL and testbench

ROUTER_PKT_TX -- requirements
Module: router_pkt_tx

---
 rtl/router_pkt_tx_if.sv | 34 +++
 rtl/router_pkt_tx.sv | 168 ++++++++++++++++
 tb/tb_router_pkt_tx.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/router_pkt_tx_if.sv
// Bus bundle for router_pkt_tx: request channel, payload channel and the
// byte stream towards the router.
//
// Handshake semantics: a request moves on a rising edge where req_valid and
// req_ready are both high. A payload byte moves on a rising edge where
// pl_valid and pl_ready are both high. A router byte moves on a rising edge
// where the transmitter presents it and busy is low; while busy is high the
// presented byte is held unchanged.
interface router_pkt_tx_if;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_dest;
    logic [5:0] req_len;
    logic       req_err;
    logic       pl_valid;
    logic [7:0] pl_data;
    logic       pl_ready;
    logic       busy;
    logic       pkt_valid;
    logic [7:0] pkt_data;
    logic       done;

    // Requester / payload source / router side
    modport master (
        output req_valid, req_dest, req_len, pl_valid, pl_data, busy,
        input  req_ready, req_err, pl_ready, pkt_valid, pkt_data, done
    );

    // Transmitter side
    modport slave (
        input  req_valid, req_dest, req_len, pl_valid, pl_data, busy,
        output req_ready, req_err, pl_ready, pkt_valid, pkt_data, done
    );
endinterface

// File: rtl/router_pkt_tx.sv
// Packet transmitter: buffers a payload, then sends header, payload and an
// XOR parity byte to a router with busy backpressure, followed by an idle gap.
// All bus outputs are registered and computed from the next state.
module router_pkt_tx #(
    parameter int GAP_CYCLES = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    router_pkt_tx_if.slave        bus,
    output logic [2:0]            o_state
);
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_HEADER  = 3'd2,
        S_PAYLOAD = 3'd3,
        S_PARITY  = 3'd4,
        S_GAP     = 3'd5
    } state_t;

    state_t     r_state, w_state_next;
    logic [1:0] r_dest, w_dest;
    logic [5:0] r_len, w_len;
    logic [5:0] r_idx, w_idx;
    logic [3:0] r_gap, w_gap;
    logic [7:0] r_parity, w_parity;
    logic       r_req_ready, w_req_ready;
    logic       r_pl_ready, w_pl_ready;
    logic       r_pkt_valid, w_pkt_valid;
    logic [7:0] r_pkt_data, w_pkt_data;
    logic       r_req_err, w_req_err;
    logic       r_done, w_done;
    logic       w_wr_en;
    logic [7:0] r_buf [0:62];
    logic [7:0] w_hdr_in, w_hdr;

    assign w_hdr_in = {bus.req_len, bus.req_dest};
    assign w_hdr    = {r_len, r_dest};

    // Next-state, datapath and next-output logic
    always_comb begin
        w_state_next = r_state;
        w_dest       = r_dest;
        w_len        = r_len;
        w_idx        = r_idx;
        w_gap        = r_gap;
        w_parity     = r_parity;
        w_pkt_valid  = r_pkt_valid;
        w_pkt_data   = r_pkt_data;
        w_req_err    = 1'b0;
        w_done       = 1'b0;
        w_wr_en      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    if (bus.req_dest == 2'd3 || bus.req_len == 6'd0) begin
                        w_req_err = 1'b1;
                    end else begin
                        w_dest       = bus.req_dest;
                        w_len        = bus.req_len;
                        w_parity     = w_hdr_in;
                        w_idx        = 6'd0;
                        w_state_next = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (bus.pl_valid && r_pl_ready) begin
                    w_wr_en  = 1'b1;
                    w_parity = r_parity ^ bus.pl_data;
                    if (r_idx == r_len - 6'd1) begin
                        w_idx        = 6'd0;
                        w_pkt_valid  = 1'b1;
                        w_pkt_data   = w_hdr;
                        w_state_next = S_HEADER;
                    end else begin
                        w_idx = r_idx + 6'd1;
                    end
                end
            end
            S_HEADER: begin
                if (!bus.busy) begin
                    w_idx        = 6'd0;
                    w_pkt_data   = r_buf[0];
                    w_state_next = S_PAYLOAD;
                end
            end
            S_PAYLOAD: begin
                if (!bus.busy) begin
                    if (r_idx == r_len - 6'd1) begin
                        w_pkt_valid  = 1'b0;
                        w_pkt_data   = r_parity;
                        w_state_next = S_PARITY;
                    end else begin
                        w_idx      = r_idx + 6'd1;
                        w_pkt_data = r_buf[r_idx + 6'd1];
                    end
                end
            end
            S_PARITY: begin
                if (!bus.busy) begin
                    w_done       = 1'b1;
                    w_pkt_data   = 8'h00;
                    w_gap        = 4'd0;
                    w_state_next = S_GAP;
                end
            end
            S_GAP: begin
                if (r_gap == 4'(GAP_CYCLES - 1)) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_gap = r_gap + 4'd1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
        w_req_ready = (w_state_next == S_IDLE);
        w_pl_ready  = (w_state_next == S_LOAD);
    end

    // State, control registers and registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_dest      <= 2'd0;
            r_len       <= 6'd0;
            r_idx       <= 6'd0;
            r_gap       <= 4'd0;
            r_parity    <= 8'h00;
            r_req_ready <= 1'b1;
            r_pl_ready  <= 1'b0;
            r_pkt_valid <= 1'b0;
            r_pkt_data  <= 8'h00;
            r_req_err   <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_dest      <= w_dest;
            r_len       <= w_len;
            r_idx       <= w_idx;
            r_gap       <= w_gap;
            r_parity    <= w_parity;
            r_req_ready <= w_req_ready;
            r_pl_ready  <= w_pl_ready;
            r_pkt_valid <= w_pkt_valid;
            r_pkt_data  <= w_pkt_data;
            r_req_err   <= w_req_err;
            r_done      <= w_done;
        end
    end

    // Payload buffer write; contents survive reset
    always_ff @(posedge i_clk) begin
        if (w_wr_en) begin
            r_buf[r_idx] <= bus.pl_data;
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.pl_ready  = r_pl_ready;
    assign bus.pkt_valid = r_pkt_valid;
    assign bus.pkt_data  = r_pkt_data;
    assign bus.req_err   = r_req_err;
    assign bus.done      = r_done;
    assign o_state       = r_state;
endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed bench for router_pkt_tx: normal packet, illegal requests, payload
// backpressure, maximum length with gappy payload, parity backpressure and
// reset mid-packet.
module tb_router_pkt_tx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  router_pkt_tx_if bus();
  logic [2:0] dbg_state;

  router_pkt_tx #(.GAP_CYCLES(2)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .bus     (bus),
    .o_state (dbg_state)
  );

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0] tx_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] mon_prev;

  // Router model: records every byte it accepts; mon_prev holds the byte
  // presented just before the latest edge (the parity byte when done rises)
  always @(posedge clk) begin
    mon_prev <= bus.pkt_data;
    if (!rst && bus.pkt_valid === 1'b1 && bus.busy === 1'b0)
      rx_q.push_back(bus.pkt_data);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send_req(input logic [1:0] d, input logic [5:0] l);
    bus.req_valid = 1'b1;
    bus.req_dest  = d;
    bus.req_len   = l;
    cyc();
    bus.req_valid = 1'b0;
  endtask

  task automatic load_payload(input bit gappy);
    foreach (tx_q[i]) begin
      if (gappy) begin
        bus.pl_valid = 1'b0;
        bus.pl_data  = 8'hEE;
        cyc();
      end
      bus.pl_valid = 1'b1;
      bus.pl_data  = tx_q[i];
      cyc();
    end
    bus.pl_valid = 1'b0;
  endtask

  task automatic wait_done(input int bound, output logic [7:0] par, output bit seen);
    seen = 1'b0;
    par  = 8'h00;
    for (int k = 0; k < bound && !seen; k++) begin
      cyc();
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        par  = mon_prev;
      end
    end
  endtask

  task automatic wait_idle(input string tag);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      if (bus.req_ready === 1'b1) ok = 1'b1;
      else cyc();
    end
    chk({tag, "_idle"}, ok, 1);
  endtask

  // Compare accepted bytes and parity against header + tx_q
  task automatic check_packet(input string tag, input int base, input logic [7:0] hdr,
                              input logic [7:0] par_obs);
    logic [7:0] par_exp;
    exp_q = {};
    exp_q.push_back(hdr);
    foreach (tx_q[i]) exp_q.push_back(tx_q[i]);
    par_exp = 8'h00;
    foreach (exp_q[i]) par_exp ^= exp_q[i];
    chk({tag, "_count"}, rx_q.size() - base, exp_q.size());
    foreach (exp_q[i]) begin
      if (base + i < rx_q.size()) chk($sformatf("%s_byte%0d", tag, i), rx_q[base + i], exp_q[i]);
      else chk($sformatf("%s_byte%0d_missing", tag, i), 0, 1);
    end
    chk({tag, "_parity"}, par_obs, par_exp);
  endtask

  initial begin
    logic [7:0] par;
    bit         seen;
    int         base;
    bit         done_any;

    bus.req_valid = 1'b0;
    bus.req_dest  = 2'd0;
    bus.req_len   = 6'd0;
    bus.pl_valid  = 1'b0;
    bus.pl_data   = 8'h00;
    bus.busy      = 1'b0;

    // Reset
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_pl_ready", bus.pl_ready, 0);
    chk("rst_pkt_valid", bus.pkt_valid, 0);
    chk("rst_pkt_data", bus.pkt_data, 8'h00);
    chk("rst_done", bus.done, 0);
    chk("rst_req_err", bus.req_err, 0);

    // Basic packet: dest 1, len 3
    base = rx_q.size();
    tx_q = '{8'hA1, 8'hB2, 8'hC3};
    send_req(2'd1, 6'd3);
    chk("t1_pl_ready", bus.pl_ready, 1);
    chk("t1_req_ready", bus.req_ready, 0);
    load_payload(1'b0);
    chk("t1_hdr_valid", bus.pkt_valid, 1);
    chk("t1_hdr_data", bus.pkt_data, 8'h0D);
    chk("t1_hdr_pl_ready", bus.pl_ready, 0);
    wait_done(20, par, seen);
    chk("t1_done_seen", seen, 1);
    chk("t1_gap_valid", bus.pkt_valid, 0);
    chk("t1_gap_data", bus.pkt_data, 8'h00);
    check_packet("t1", base, 8'h0D, par);
    cyc();
    chk("t1_done_one_cycle", bus.done, 0);
    chk("t1_gap2_req_ready", bus.req_ready, 0);
    cyc();
    chk("t1_idle_req_ready", bus.req_ready, 1);

    // Illegal requests
    send_req(2'd3, 6'd5);
    chk("t2_err_dest", bus.req_err, 1);
    chk("t2_err_dest_ready", bus.req_ready, 1);
    chk("t2_err_dest_pl_ready", bus.pl_ready, 0);
    chk("t2_err_dest_valid", bus.pkt_valid, 0);
    cyc();
    chk("t2_err_pulse", bus.req_err, 0);
    send_req(2'd0, 6'd0);
    chk("t2_err_len", bus.req_err, 1);
    chk("t2_err_len_ready", bus.req_ready, 1);
    chk("t2_err_len_pl_ready", bus.pl_ready, 0);
    cyc();
    chk("t2_err_len_pulse", bus.req_err, 0);

    // Busy held 4 cycles on payload byte 2, with gappy payload input
    base = rx_q.size();
    tx_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    send_req(2'd0, 6'd4);
    load_payload(1'b1);
    chk("t3_hdr_data", bus.pkt_data, 8'h10);
    cyc();
    chk("t3_byte1", bus.pkt_data, 8'h11);
    cyc();
    chk("t3_byte2", bus.pkt_data, 8'h22);
    bus.busy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc();
      chk($sformatf("t3_hold_data%0d", k), bus.pkt_data, 8'h22);
      chk($sformatf("t3_hold_valid%0d", k), bus.pkt_valid, 1);
    end
    bus.busy = 1'b0;
    cyc();
    chk("t3_byte3", bus.pkt_data, 8'h33);
    wait_done(20, par, seen);
    chk("t3_done_seen", seen, 1);
    check_packet("t3", base, 8'h10, par);
    wait_idle("t3");

    // Maximum length, pl_valid toggling
    base = rx_q.size();
    tx_q = {};
    for (int i = 0; i < 63; i++) tx_q.push_back(8'(i * 7 + 3));
    send_req(2'd2, 6'd63);
    load_payload(1'b1);
    chk("t4_hdr_data", bus.pkt_data, 8'hFE);
    wait_done(200, par, seen);
    chk("t4_done_seen", seen, 1);
    check_packet("t4", base, 8'hFE, par);
    wait_idle("t4");

    // Busy held through PARITY for 3 cycles
    base = rx_q.size();
    tx_q = '{8'h77};
    send_req(2'd0, 6'd1);
    load_payload(1'b0);
    chk("t6_hdr_data", bus.pkt_data, 8'h04);
    cyc();
    chk("t6_byte", bus.pkt_data, 8'h77);
    cyc();
    chk("t6_par_valid", bus.pkt_valid, 0);
    chk("t6_par_data", bus.pkt_data, 8'h73);
    bus.busy = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk($sformatf("t6_hold_data%0d", k), bus.pkt_data, 8'h73);
      chk($sformatf("t6_hold_valid%0d", k), bus.pkt_valid, 0);
      chk($sformatf("t6_hold_done%0d", k), bus.done, 0);
    end
    bus.busy = 1'b0;
    cyc();
    chk("t6_done", bus.done, 1);
    chk("t6_gap_data", bus.pkt_data, 8'h00);
    check_packet("t6", base, 8'h04, mon_prev);
    wait_idle("t6");

    // Reset on payload byte 10, then a clean packet
    tx_q = {};
    for (int i = 0; i < 20; i++) tx_q.push_back(8'h30 + 8'(i));
    send_req(2'd1, 6'd20);
    load_payload(1'b0);
    for (int k = 0; k < 10; k++) cyc();
    chk("t5_byte10", bus.pkt_data, tx_q[9]);
    chk("t5_byte10_valid", bus.pkt_valid, 1);
    rst = 1'b1;
    cyc();
    chk("t5_rst_valid", bus.pkt_valid, 0);
    chk("t5_rst_done", bus.done, 0);
    rst = 1'b0;
    cyc();
    chk("t5_post_req_ready", bus.req_ready, 1);
    chk("t5_post_pl_ready", bus.pl_ready, 0);
    done_any = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cyc();
      if (bus.done === 1'b1) done_any = 1'b1;
    end
    chk("t5_no_done", done_any, 0);
    base = rx_q.size();
    tx_q = '{8'h5A, 8'hA5};
    send_req(2'd2, 6'd2);
    load_payload(1'b0);
    chk("t5b_hdr_data", bus.pkt_data, 8'h0A);
    wait_done(20, par, seen);
    chk("t5b_done_seen", seen, 1);
    check_packet("t5b", base, 8'h0A, par);
    wait_idle("t5b");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
